control_ventilacion: RTL and testbench
======================================

# control_ventilacion

Sequential controller that produces the `Ventilacion` and `Alarma` signals consumed by the 7-segment activation display. It synchronizes and debounces two temperature-threshold inputs from the sensor comparator/switches. It then runs a Moore FSM that enforces a minimum fan on-time and escalates to an alarm when overheating persists or becomes critical. It sits between the board inputs and the display/actuator logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required before a filtered input changes. Range ≥1.
- `MIN_ON_CYCLES`, default 16: minimum cycles `Ventilacion` stays high in VENTILANDO. Range ≥1.
- `ALARM_DELAY_CYCLES`, default 32: consecutive cycles of `Temp_alta` while ventilating before the alarm fires. Range ≥1.
- `CNT_W`, default 8: width of all internal counters. Every count parameter must be < 2^CNT_W.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `Temp_alta` in 1: asynchronous, raw flag "temperature above normal threshold".
- `Temp_critica` in 1: asynchronous, raw flag "temperature above critical threshold".
- `Reconocer` in 1: operator acknowledge, level-sensitive. Ignored unless `ALARMA_LATCH_EN` is defined.
- `Ventilacion` out 1: fan on.
- `Alarma` out 1: alarm on.
- `Estado` out 2: current FSM state, for debug/LEDs.

## Operation
- Each raw input, including `Reconocer`, passes through a 2-flop synchronizer and then a debouncer.
- Debouncer behaviour:
  - The counter increments on every edge where synced ≠ filtered.
  - The counter clears whenever synced == filtered.
  - When synced ≠ filtered and counter == DEBOUNCE_CYCLES−1, filtered <= synced and the counter clears.
- FSM states: REPOSO=2'b00, VENTILANDO=2'b01, ALARMA=2'b10. 2'b11 is illegal and recovers to REPOSO on the next edge.
- REPOSO:
  - If `tc_f`, go to ALARMA.
  - Else if `ta_f`, go to VENTILANDO.
  - On entry to VENTILANDO, `on_cnt` and `al_cnt` are cleared.
- VENTILANDO:
  - `on_cnt` increments each cycle, saturating at MIN_ON_CYCLES.
  - Priority 1: if `tc_f`, go to ALARMA.
  - Priority 2: else if `ta_f`, `al_cnt` increments. If `al_cnt` == ALARM_DELAY_CYCLES−1, go to ALARMA.
  - Priority 3: else clear `al_cnt`. If `on_cnt` ≥ MIN_ON_CYCLES−1, go to REPOSO; otherwise stay.
- ALARMA:
  - When `ta_f`=0 and `tc_f`=0, go to VENTILANDO with `on_cnt` and `al_cnt` cleared. The minimum on-time therefore restarts.
- Outputs are Moore-decoded from the state register only; there is no combinational path from input to output.
  - REPOSO: `Ventilacion`=0, `Alarma`=0.
  - VENTILANDO: `Ventilacion`=1, `Alarma`=0.
  - ALARMA: `Ventilacion`=1, `Alarma`=1.
- Simultaneous `ta_f` and `tc_f`: `tc_f` wins.
- Counters never wrap; `al_cnt` cannot exceed ALARM_DELAY_CYCLES−1.

## Timing
- Reset, at the edge where `reset`=1:
  - state goes to REPOSO;
  - synchronizers, filtered values and all counters go to 0;
  - `Ventilacion`=0, `Alarma`=0, `Estado`=2'b00.
- Reset asserted mid-operation takes effect on that same edge and overrides all transitions.
- Input-to-output latency: a raw level stable from sampling edge 0 changes the outputs after edge 2+DEBOUNCE_CYCLES. That is 6 edges by default: the output is visible after the 7th edge (edge index 6).
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no output change.
- Minimum `Ventilacion` high time in VENTILANDO is exactly MIN_ON_CYCLES cycles.
- `Alarma` rises ALARM_DELAY_CYCLES cycles after `Ventilacion` when `ta_f` is held continuously and `tc_f` stays low.

## Configuration
- `ALARMA_LATCH_EN` defined:
  - ALARMA exits only when `ta_f`=0, `tc_f`=0 and filtered `Reconocer`=1 in the same cycle.
  - `Reconocer` asserted while the condition is still present is ignored.
- `ALARMA_LATCH_EN` undefined:
  - The alarm self-clears as soon as both filtered flags are 0.
  - The `Reconocer` synchronizer/debouncer is not instantiated; the port is left unused.

## Structure
- Shared package contents:
  - state encodings REPOSO/VENTILANDO/ALARMA;
  - default values for the three count parameters;
  - default `CNT_W`.
- Sub-module `antirrebote`: contains the synchronizer and debouncer, parameterized by DEBOUNCE_CYCLES and CNT_W. It is instantiated once per input (2 or 3 instances).
- The top level holds the FSM, `on_cnt`, `al_cnt` and the output decode.

## Test plan
All scenarios use default parameters.
1. `reset` held 2 cycles with random inputs -> `Ventilacion`=0, `Alarma`=0, `Estado`=00 from the first reset edge. Assert `reset` mid-VENTILANDO -> 00 on the next edge.
2. `Temp_alta` pulses of 1, 2 and 3 cycles -> no output change; `Estado` stays 00.
3. `Temp_alta` high from edge 0 for 8 cycles, then low -> `Ventilacion` rises after edge 6 and stays high exactly 16 cycles, then `Estado`=00.
4. `Temp_alta` held high for 60 cycles -> `Alarma` rises 32 cycles after `Ventilacion`. After `Temp_alta` drops: `Alarma` falls 6 edges later, and `Ventilacion` stays high 16 further cycles.
5. `Temp_critica` and `Temp_alta` raised together from REPOSO -> `Estado` goes directly 00→10; both outputs rise after edge 6.
6. With `ALARMA_LATCH_EN`: clear both flags while in ALARMA -> `Alarma` stays 1. Hold `Reconocer` 6 cycles -> `Estado`=01 one edge after the filtered `Reconocer` rises. Repeat with `Reconocer` during `Temp_critica` -> still ALARMA.

Source files
------------

// File: rtl/control_ventilacion_pkg.sv
// Shared definitions for the fan/alarm controller: state encodings and
// default values for the count parameters.
package control_ventilacion_pkg;

  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    VENTILANDO = 2'b01,
    ALARMA     = 2'b10
  } estado_t;

  localparam int DEF_DEBOUNCE_CYCLES    = 4;
  localparam int DEF_MIN_ON_CYCLES      = 16;
  localparam int DEF_ALARM_DELAY_CYCLES = 32;
  localparam int DEF_CNT_W              = 8;

endpackage

// File: rtl/control_ventilacion_antirrebote.sv
// Two-flop synchronizer followed by a debouncer: the filtered level follows
// the synchronized input only after DEBOUNCE_CYCLES consecutive differing samples.
import control_ventilacion_pkg::*;

module antirrebote #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic filtered
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (sync_reg[1] != filt_reg) begin
        if (cnt_reg == LAST) begin
          filt_reg <= sync_reg[1];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign filtered = filt_reg;

endmodule

// File: rtl/control_ventilacion.sv
// Fan/alarm Moore FSM with minimum fan on-time and alarm escalation.
// Define ALARMA_LATCH_EN to require a filtered Reconocer before leaving ALARMA.
import control_ventilacion_pkg::*;

module control_ventilacion #(
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_ON_CYCLES      = DEF_MIN_ON_CYCLES,
  parameter int ALARM_DELAY_CYCLES = DEF_ALARM_DELAY_CYCLES,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Temp_alta,
  input  logic       Temp_critica,
  input  logic       Reconocer,
  output logic       Ventilacion,
  output logic       Alarma,
  output logic [1:0] Estado
);

`ifdef ALARMA_LATCH_EN
  localparam int N_IN = 3;
`else
  localparam int N_IN = 2;
`endif

  localparam logic [CNT_W-1:0] ON_MAX  = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] AL_LAST = CNT_W'(ALARM_DELAY_CYCLES - 1);

  logic [N_IN-1:0]  raw_vec;
  logic [N_IN-1:0]  filt_vec;
  logic             ta_f;
  logic             tc_f;
  logic             salir_alarma;
  estado_t          state_reg, state_next;
  logic [CNT_W-1:0] on_cnt_reg, on_cnt_next;
  logic [CNT_W-1:0] al_cnt_reg, al_cnt_next;

`ifdef ALARMA_LATCH_EN
  assign raw_vec = {Reconocer, Temp_critica, Temp_alta};
`else
  logic unused_reconocer;
  assign unused_reconocer = Reconocer;
  assign raw_vec = {Temp_critica, Temp_alta};
`endif

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_filtro
      antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_antirrebote (
        .clk     (clk),
        .srst    (reset),
        .raw     (raw_vec[gi]),
        .filtered(filt_vec[gi])
      );
    end
  endgenerate

  assign ta_f = filt_vec[0];
  assign tc_f = filt_vec[1];

`ifdef ALARMA_LATCH_EN
  assign salir_alarma = !ta_f && !tc_f && filt_vec[2];
`else
  assign salir_alarma = !ta_f && !tc_f;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= REPOSO;
      on_cnt_reg <= '0;
      al_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      on_cnt_reg <= on_cnt_next;
      al_cnt_reg <= al_cnt_next;
    end
  end

  // Counters are zero whenever VENTILANDO is entered, from any state.
  always_comb begin
    state_next  = REPOSO;
    on_cnt_next = '0;
    al_cnt_next = '0;
    case (state_reg)
      REPOSO: begin
        if (tc_f)      state_next = ALARMA;
        else if (ta_f) state_next = VENTILANDO;
      end
      VENTILANDO: begin
        state_next  = VENTILANDO;
        on_cnt_next = (on_cnt_reg < ON_MAX) ? on_cnt_reg + CNT_W'(1) : on_cnt_reg;
        al_cnt_next = al_cnt_reg;
        if (tc_f) begin
          state_next = ALARMA;
        end else if (ta_f) begin
          if (al_cnt_reg == AL_LAST) state_next = ALARMA;
          else                       al_cnt_next = al_cnt_reg + CNT_W'(1);
        end else begin
          al_cnt_next = '0;
          if (on_cnt_reg >= ON_LAST) state_next = REPOSO;
        end
      end
      ALARMA: begin
        state_next = salir_alarma ? VENTILANDO : ALARMA;
      end
      default: state_next = REPOSO;
    endcase
  end

  assign Ventilacion = (state_reg == VENTILANDO) || (state_reg == ALARMA);
  assign Alarma      = (state_reg == ALARMA);
  assign Estado      = state_reg;

endmodule

// File: tb/tb_control_ventilacion.sv
// Directed bench for control_ventilacion: expected {Ventilacion,Alarma,Estado}
// per cycle is queued before each edge and compared after it.
module tb_control_ventilacion;

  localparam logic [3:0] E_REP = 4'b0000;
  localparam logic [3:0] E_VEN = 4'b1001;
  localparam logic [3:0] E_ALM = 4'b1110;

  logic       clk = 1'b0;
  logic       reset;
  logic       Temp_alta;
  logic       Temp_critica;
  logic       Reconocer;
  logic       Ventilacion;
  logic       Alarma;
  logic [1:0] Estado;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  control_ventilacion dut (
    .clk         (clk),
    .reset       (reset),
    .Temp_alta   (Temp_alta),
    .Temp_critica(Temp_critica),
    .Reconocer   (Reconocer),
    .Ventilacion (Ventilacion),
    .Alarma      (Alarma),
    .Estado      (Estado)
  );

  always #5 clk = ~clk;

  // Queue n expectations, one per upcoming edge, and check each after its edge.
  task automatic run(input int n, input logic [3:0] expv, input string tag);
    logic [3:0] obs;
    logic [3:0] e;
    string      t;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      cycle++;
      obs = {Ventilacion, Alarma, Estado};
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $display("FAIL %s step %0d cycle %0d: observed=%b expected=%b", t, i, cycle, obs, e);
        $error("%s: observed=%b expected=%b", t, obs, e);
      end
      $display("cycle %0d %s: V=%b A=%b Estado=%b exp=%b", cycle, t, obs[3], obs[2], obs[1:0], e);
    end
  endtask

  initial begin
    // Reset held two cycles with random inputs
    reset        = 1'b1;
    Temp_alta    = 1'($urandom_range(0, 1));
    Temp_critica = 1'($urandom_range(0, 1));
    Reconocer    = 1'($urandom_range(0, 1));
    run(1, E_REP, "reset_edge0");
    Temp_alta    = 1'($urandom_range(0, 1));
    Temp_critica = 1'($urandom_range(0, 1));
    run(1, E_REP, "reset_edge1");
    reset = 1'b0; Temp_alta = 1'b0; Temp_critica = 1'b0; Reconocer = 1'b0;
    run(4, E_REP, "idle_after_reset");

    // Short Temp_alta glitches are filtered out
    for (int w = 1; w <= 3; w++) begin
      Temp_alta = 1'b1;
      run(w, E_REP, "glitch_high");
      Temp_alta = 1'b0;
      run(8, E_REP, "glitch_after");
    end

    // 8-cycle Temp_alta: fan on after edge 6, held exactly 16 cycles
    Temp_alta = 1'b1;
    run(6, E_REP, "ta8_latency");
    run(2, E_VEN, "ta8_on");
    Temp_alta = 1'b0;
    run(14, E_VEN, "ta8_min_on");
    run(6, E_REP, "ta8_off");

    // Reset mid-VENTILANDO
    Temp_alta = 1'b1;
    run(6, E_REP, "rst_mid_latency");
    run(3, E_VEN, "rst_mid_on");
    reset = 1'b1; Temp_alta = 1'b0;
    run(2, E_REP, "rst_mid_reset");
    reset = 1'b0;
    run(8, E_REP, "rst_mid_idle");

    // Persistent Temp_alta escalates to alarm 32 cycles after fan on
    Temp_alta = 1'b1;
    run(6, E_REP, "ta60_latency");
    run(32, E_VEN, "ta60_ventilando");
    run(22, E_ALM, "ta60_alarma");
    Temp_alta = 1'b0;
    run(6, E_ALM, "ta60_alarma_hold");
    run(16, E_VEN, "ta60_min_on");
    run(4, E_REP, "ta60_reposo");

    // Critical + high together: straight to ALARMA
    Temp_alta = 1'b1; Temp_critica = 1'b1;
    run(6, E_REP, "tc_latency");
    run(4, E_ALM, "tc_alarma");
    Temp_alta = 1'b0; Temp_critica = 1'b0;
    run(6, E_ALM, "tc_alarma_hold");
`ifdef ALARMA_LATCH_EN
    run(5, E_ALM, "latch_no_ack");
    Reconocer = 1'b1;
    run(6, E_ALM, "latch_ack_filter");
    Reconocer = 1'b0;
    run(16, E_VEN, "latch_ack_min_on");
    run(4, E_REP, "latch_ack_reposo");

    // Acknowledge while critical is still present is ignored
    Temp_critica = 1'b1;
    run(6, E_REP, "latch_tc_latency");
    run(4, E_ALM, "latch_tc_alarma");
    Reconocer = 1'b1;
    run(6, E_ALM, "latch_tc_ack_ignored");
    Reconocer = 1'b0;
    run(10, E_ALM, "latch_tc_hold");
    Temp_critica = 1'b0;
    run(16, E_ALM, "latch_tc_cleared");
    Reconocer = 1'b1;
    run(6, E_ALM, "latch_tc_ack2");
    Reconocer = 1'b0;
    run(16, E_VEN, "latch_tc_min_on");
    run(4, E_REP, "latch_tc_reposo");
`else
    run(16, E_VEN, "tc_min_on");
    run(4, E_REP, "tc_reposo");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
